bits_cols_rcon: RTL and testbench

Registered helper for the AES key-schedule datapath. It combines three functions:
- splits a flat key vector into 32-bit AES words;
- packs an array of 32-bit words back into a flat vector;
- produces the round-constant word for a given round index.

All three results are registered together under a single valid strobe with one-cycle latency. The block sits between the key register and the word-level expansion logic (rotate, substitute, XOR).

---
 rtl/bits_cols_rcon.sv | 77 +++++++
 tb/tb_bits_cols_rcon.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bits_cols_rcon.sv
// AES key-schedule helper: splits a key into 32-bit words, merges words back
// into a flat vector and produces the round-constant word, all registered together.
module bits_cols_rcon #(
  parameter  int KEY_SIZE = 128,
  localparam int COL_NUM  = KEY_SIZE / 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [KEY_SIZE-1:0]     key_bits,
  input  logic [COL_NUM*32-1:0]   cols_in,
  input  logic [3:0]              rcon_idx,
  output logic                    out_valid,
  output logic [COL_NUM*32-1:0]   cols_out,
  output logic [KEY_SIZE-1:0]     bits_out,
  output logic [31:0]             rcon_word
);

  if (!(KEY_SIZE == 128 || KEY_SIZE == 192 || KEY_SIZE == 256)) begin : g_bad_key_size
    $error("bits_cols_rcon: KEY_SIZE must be 128, 192 or 256");
  end

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // rc(1) = 01, each further round doubles in GF(2^8); 0 and 11..15 yield zero
  function automatic logic [7:0] rc_byte(input logic [3:0] idx);
    logic [7:0] rc;
    rc = 8'h01;
    for (int unsigned n = 2; n <= 10; n++) begin
      if (32'(idx) >= n) rc = xtime(rc);
    end
    if (idx == 4'd0 || idx > 4'd10) rc = '0;
    return rc;
  endfunction

  logic                  out_valid_q, out_valid_d;
  logic [COL_NUM*32-1:0] cols_out_q,  cols_out_d;
  logic [KEY_SIZE-1:0]   bits_out_q,  bits_out_d;
  logic [31:0]           rcon_word_q, rcon_word_d;

  always_comb begin
    out_valid_d = in_valid;
    cols_out_d  = cols_out_q;
    bits_out_d  = bits_out_q;
    rcon_word_d = rcon_word_q;
    if (in_valid) begin
      // AES w0 is the most significant key word but sits in the lowest port slot
      for (int unsigned i = 0; i < COL_NUM; i++) begin
        cols_out_d[32*i +: 32]           = key_bits[KEY_SIZE-1-32*i -: 32];
        bits_out_d[KEY_SIZE-1-32*i -: 32] = cols_in[32*i +: 32];
      end
      rcon_word_d = {rc_byte(rcon_idx), 24'h000000};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      cols_out_q  <= '0;
      bits_out_q  <= '0;
      rcon_word_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      cols_out_q  <= cols_out_d;
      bits_out_q  <= bits_out_d;
      rcon_word_q <= rcon_word_d;
    end
  end

  assign out_valid = out_valid_q;
  assign cols_out  = cols_out_q;
  assign bits_out  = bits_out_q;
  assign rcon_word = rcon_word_q;

endmodule

// File: tb/tb_bits_cols_rcon.sv
// Directed bench for bits_cols_rcon at all three key sizes.
module tb_bits_cols_rcon;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [3:0] rcon_idx = '0;

  logic [127:0] key128 = '0, cin128 = '0, cout128, bout128;
  logic [191:0] key192 = '0, cin192 = '0, cout192, bout192;
  logic [255:0] key256 = '0, cin256 = '0, cout256, bout256;
  logic v128, v192, v256;
  logic [31:0] rw128, rw192, rw256;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bits_cols_rcon #(.KEY_SIZE(128)) u128 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .key_bits(key128), .cols_in(cin128),
    .rcon_idx(rcon_idx), .out_valid(v128), .cols_out(cout128), .bits_out(bout128), .rcon_word(rw128));
  bits_cols_rcon #(.KEY_SIZE(192)) u192 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .key_bits(key192), .cols_in(cin192),
    .rcon_idx(rcon_idx), .out_valid(v192), .cols_out(cout192), .bits_out(bout192), .rcon_word(rw192));
  bits_cols_rcon #(.KEY_SIZE(256)) u256 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .key_bits(key256), .cols_in(cin256),
    .rcon_idx(rcon_idx), .out_valid(v256), .cols_out(cout256), .bits_out(bout256), .rcon_word(rw256));

  task automatic test_reset();
    @(negedge clk);
    in_valid = 1'b1;
    key128 = '1; cin128 = '1; rcon_idx = 4'd1;
    @(posedge clk); #1;
    checks++;
    if ({v128, v192, v256} !== 3'b000) begin
      errors++; $display("FAIL reset_valid got %b exp 000", {v128, v192, v256});
    end
    checks++;
    if ({cout128, bout128, rw128} !== '0) begin
      errors++; $display("FAIL reset_data128 got %h %h %h exp 0", cout128, bout128, rw128);
    end
    checks++;
    if ({cout256, bout256, rw256, cout192, bout192, rw192} !== '0) begin
      errors++; $display("FAIL reset_data192_256 got nonzero exp 0");
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({v128, cout128, bout128, rw128} !== '0) begin
      errors++; $display("FAIL reset_release got v=%b %h %h %h exp 0", v128, cout128, bout128, rw128);
    end
  endtask

  task automatic test_split128();
    @(negedge clk);
    in_valid = 1'b1;
    key128 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    @(posedge clk); #1;
    checks++;
    if (v128 !== 1'b1) begin
      errors++; $display("FAIL split128_valid got %b exp 1", v128);
    end
    checks++;
    if (cout128 !== 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516) begin
      errors++; $display("FAIL split128_cols got %h exp 09cf4f3cabf7158828aed2a62b7e1516", cout128);
    end
    checks++;
    if (cout128[31:0] !== 32'h2b7e1516) begin
      errors++; $display("FAIL split128_word0 got %h exp 2b7e1516", cout128[31:0]);
    end
  endtask

  task automatic test_rcon_sweep();
    logic [31:0] exp_rc [16] = '{32'h00000000, 32'h01000000, 32'h02000000, 32'h04000000,
                                 32'h08000000, 32'h10000000, 32'h20000000, 32'h40000000,
                                 32'h80000000, 32'h1b000000, 32'h36000000, 32'h00000000,
                                 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      rcon_idx = 4'(i);
      @(posedge clk); #1;
      checks++;
      if (rw128 !== exp_rc[i] || v128 !== 1'b1) begin
        errors++; $display("FAIL rcon_idx%0d got %h v=%b exp %h v=1", i, rw128, v128, exp_rc[i]);
      end
      checks++;
      if (rw256 !== exp_rc[i]) begin
        errors++; $display("FAIL rcon256_idx%0d got %h exp %h", i, rw256, exp_rc[i]);
      end
    end
  endtask

  task automatic test_roundtrip256();
    logic [255:0] k;
    k = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;
    @(negedge clk);
    in_valid = 1'b1;
    key256 = k;
    @(posedge clk); #1;
    checks++;
    if (cout256[255:224] !== 32'h0914dff4) begin
      errors++; $display("FAIL rt256_word7 got %h exp 0914dff4", cout256[255:224]);
    end
    checks++;
    if (cout256[31:0] !== 32'h603deb10) begin
      errors++; $display("FAIL rt256_word0 got %h exp 603deb10", cout256[31:0]);
    end
    @(negedge clk);
    cin256 = cout256;
    key256 = '0;
    @(posedge clk); #1;
    checks++;
    if (bout256 !== k) begin
      errors++; $display("FAIL rt256_merge got %h exp %h", bout256, k);
    end
  endtask

  task automatic test_split192();
    @(negedge clk);
    in_valid = 1'b1;
    key192 = 192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b;
    cin192 = 192'h00000006_00000005_00000004_00000003_00000002_00000001;
    @(posedge clk); #1;
    checks++;
    if (cout192[191:160] !== 32'h522c6b7b || cout192[31:0] !== 32'h8e73b0f7) begin
      errors++; $display("FAIL split192_ends got w5=%h w0=%h exp 522c6b7b 8e73b0f7",
                         cout192[191:160], cout192[31:0]);
    end
    checks++;
    if (bout192 !== 192'h00000001_00000002_00000003_00000004_00000005_00000006) begin
      errors++; $display("FAIL merge192 got %h exp 000000010000000200000003000000040000000500000006", bout192);
    end
  endtask

  task automatic test_hold_reset();
    @(negedge clk);
    in_valid = 1'b1;
    key128 = 128'h00112233_44556677_8899aabb_ccddeeff;
    cin128 = 128'hdeadbeef_00000000_00000000_cafef00d;
    rcon_idx = 4'd10;
    @(posedge clk); #1;
    @(negedge clk);
    in_valid = 1'b0;
    key128 = '1; cin128 = '1; rcon_idx = 4'd3;
    @(posedge clk); #1;
    checks++;
    if (v128 !== 1'b0) begin
      errors++; $display("FAIL hold_valid got %b exp 0", v128);
    end
    checks++;
    if (cout128 !== 128'hccddeeff_8899aabb_44556677_00112233 ||
        bout128 !== 128'hcafef00d_00000000_00000000_deadbeef || rw128 !== 32'h36000000) begin
      errors++; $display("FAIL hold_data got %h %h %h exp ccddeeff8899aabb4455667700112233 cafef00d0000000000000000deadbeef 36000000",
                         cout128, bout128, rw128);
    end
    #2;
    in_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({v128, cout128, bout128, rw128} !== '0) begin
      errors++; $display("FAIL async_reset got v=%b %h %h %h exp 0", v128, cout128, bout128, rw128);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [127:0] keys [8];
    logic [127:0] cins [8];
    logic [127:0] ek, ec;
    for (int j = 0; j < 8; j++) begin
      keys[j] = {$urandom, $urandom, $urandom, $urandom};
      cins[j] = {$urandom, $urandom, $urandom, $urandom};
    end
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      in_valid = 1'b1;
      key128 = keys[j];
      cin128 = cins[j];
      rcon_idx = 4'(j + 1);
      @(posedge clk); #1;
      ek = {keys[j][31:0], keys[j][63:32], keys[j][95:64], keys[j][127:96]};
      ec = {cins[j][31:0], cins[j][63:32], cins[j][95:64], cins[j][127:96]};
      checks++;
      if (v128 !== 1'b1 || cout128 !== ek || bout128 !== ec || rw128 !== (32'h01000000 << j)) begin
        errors++; $display("FAIL b2b_%0d got v=%b %h %h %h exp v=1 %h %h %h",
                           j, v128, cout128, bout128, rw128, ek, ec, 32'h01000000 << j);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (v128 !== 1'b0) begin
      errors++; $display("FAIL b2b_end_valid got %b exp 0", v128);
    end
  endtask

  initial begin
    test_reset();
    test_split128();
    test_rcon_sweep();
    test_roundtrip256();
    test_split192();
    test_hold_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
